// File: rtl/mem_pattern_tester_pkg.sv
// Shared types and constants for the block-RAM pattern self-test controller.
package mem_pattern_tester_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam logic [1:0] PAT_ADDR  = 2'd0;
    localparam logic [1:0] PAT_CHECK = 2'd1;
    localparam logic [1:0] PAT_NADDR = 2'd2;
    localparam logic [1:0] PAT_LFSR  = 2'd3;

    localparam int unsigned LFSR_W = 8;
    // Fibonacci taps for x^8+x^6+x^5+x^4+1, shifting toward the MSB
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] q);
        return {q[LFSR_W-2:0], ^(q & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/mem_pattern_gen.sv
// Pattern generator: combinational pattern mux plus the LFSR state for pattern 3.
module mem_pattern_gen
    import mem_pattern_tester_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 9,
    parameter int unsigned       DATA_W    = 8,
    parameter logic [LFSR_W-1:0] LFSR_SEED = 8'hA5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        pat_sel,
    input  logic [ADDR_W-1:0] addr,
    input  logic              load,
    input  logic              advance,
    output logic [DATA_W-1:0] pattern_c
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_cur;
    logic [DATA_W-1:0] chk;

    // A load makes the seed visible in the same cycle, so the first address needs no bubble
    assign lfsr_cur = load ? LFSR_SEED : lfsr_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr_q <= LFSR_SEED;
        end else if (advance) begin
            lfsr_q <= lfsr_step(lfsr_cur);
        end else if (load) begin
            lfsr_q <= LFSR_SEED;
        end
    end

    always_comb begin
        chk = '0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            chk[i] = (i[0] == addr[0]);
        end
        pattern_c = DATA_W'(addr);
        case (pat_sel)
            PAT_ADDR:  pattern_c = DATA_W'(addr);
            PAT_CHECK: pattern_c = chk;
            PAT_NADDR: pattern_c = ~(DATA_W'(addr));
            PAT_LFSR:  pattern_c = DATA_W'(lfsr_cur);
            default:   pattern_c = DATA_W'(addr);
        endcase
    end

endmodule

// File: rtl/mem_pattern_tester.sv
// BIST controller: fills the RAM with a pattern, reads it back and reports mismatches.
module mem_pattern_tester
    import mem_pattern_tester_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 9,
    parameter int unsigned       DATA_W    = 8,
    parameter int unsigned       ERR_W     = 16,
    parameter logic [LFSR_W-1:0] LFSR_SEED = 8'hA5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        pattern_sel,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_cs,
    output logic              mem_rw,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_count,
    output logic [ADDR_W-1:0] first_err_addr
);

    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
    localparam logic [ERR_W-1:0]  ERR_MAX   = '1;

    state_t state_q, state_n;
    logic [1:0]        pat_q, pat_n;
    logic [DATA_W-1:0] exp_q, exp_n, exp_d;
    logic              cmp_v;
    logic [ADDR_W-1:0] cmp_addr;

    logic [ADDR_W-1:0] addr_n, first_n;
    logic              cs_n, rw_n, busy_n, done_n, pass_n;
    logic [DATA_W-1:0] wdata_n;
    logic [ERR_W-1:0]  err_n;

    logic [1:0]        gen_pat;
    logic [ADDR_W-1:0] gen_addr;
    logic              gen_load, gen_adv;
    logic [DATA_W-1:0] pattern_c;

    mem_pattern_gen #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .LFSR_SEED (LFSR_SEED)
    ) u_gen (
        .clk       (clk),
        .reset     (reset),
        .pat_sel   (gen_pat),
        .addr      (gen_addr),
        .load      (gen_load),
        .advance   (gen_adv),
        .pattern_c (pattern_c)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // Next state and next values of every registered output
    always_comb begin
        state_n  = state_q;
        pat_n    = pat_q;
        exp_n    = exp_q;
        addr_n   = mem_addr;
        cs_n     = mem_cs;
        rw_n     = mem_rw;
        wdata_n  = mem_wdata;
        busy_n   = busy;
        done_n   = done;
        err_n    = err_count;
        first_n  = first_err_addr;
        gen_pat  = pat_q;
        gen_addr = ADDR_W'(mem_addr + 1'b1);
        gen_load = 1'b0;
        gen_adv  = 1'b0;

        // Read data trails its address by one cycle; cmp_addr/exp_d carry the matching context
        if (cmp_v && (mem_rdata != exp_d)) begin
            if (err_count == '0) begin
                first_n = cmp_addr;
            end
            if (err_count != ERR_MAX) begin
                err_n = ERR_W'(err_count + 1'b1);
            end
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_n  = ST_WRITE;
                    pat_n    = pattern_sel;
                    gen_pat  = pattern_sel;
                    gen_addr = '0;
                    gen_load = 1'b1;
                    gen_adv  = 1'b1;
                    addr_n   = '0;
                    cs_n     = 1'b1;
                    rw_n     = 1'b1;
                    wdata_n  = pattern_c;
                    busy_n   = 1'b1;
                    done_n   = 1'b0;
                    err_n    = '0;
                    first_n  = '0;
                end
            end
            ST_WRITE: begin
                gen_adv = 1'b1;
                if (mem_addr == ADDR_LAST) begin
                    state_n  = ST_READ;
                    gen_addr = '0;
                    gen_load = 1'b1;
                    addr_n   = '0;
                    rw_n     = 1'b0;
                    exp_n    = pattern_c;
                end else begin
                    addr_n  = ADDR_W'(mem_addr + 1'b1);
                    wdata_n = pattern_c;
                end
            end
            ST_READ: begin
                if (mem_addr == ADDR_LAST) begin
                    state_n = ST_DRAIN;
                end else begin
                    gen_adv = 1'b1;
                    addr_n  = ADDR_W'(mem_addr + 1'b1);
                    exp_n   = pattern_c;
                end
            end
            ST_DRAIN: begin
                state_n = ST_DONE;
                cs_n    = 1'b0;
                rw_n    = 1'b0;
                busy_n  = 1'b0;
                done_n  = 1'b1;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        pass_n = done_n && (err_n == '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pat_q          <= PAT_ADDR;
            exp_q          <= '0;
            exp_d          <= '0;
            cmp_v          <= 1'b0;
            cmp_addr       <= '0;
            mem_addr       <= '0;
            mem_cs         <= 1'b0;
            mem_rw         <= 1'b0;
            mem_wdata      <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
        end else begin
            pat_q          <= pat_n;
            exp_q          <= exp_n;
            exp_d          <= exp_q;
            cmp_v          <= (state_q == ST_READ);
            cmp_addr       <= mem_addr;
            mem_addr       <= addr_n;
            mem_cs         <= cs_n;
            mem_rw         <= rw_n;
            mem_wdata      <= wdata_n;
            busy           <= busy_n;
            done           <= done_n;
            pass           <= pass_n;
            err_count      <= err_n;
            first_err_addr <= first_n;
        end
    end

endmodule
